// File: rtl/fetch_pkg.sv
// Shared types for the instruction prefetch queue.
// Holds the buffered {pc, instr} entry and fetch constants.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] FQ_NOP  = 32'h0;

endpackage

// File: rtl/fq_fifo.sv
// Synchronous FIFO of fetch entries with a single-cycle clear.
// Head is read combinationally; pointers wrap modulo DEPTH.
module fq_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  fq_entry_t                  din,
  output fq_entry_t                  dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fq_entry_t     mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clear && !rst) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Prefetch queue ahead of IF: issues sequential IM fetches,
// buffers returned words and flushes on EX redirects.
module ifetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_gnt,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = CW + OW + 1;

  localparam logic RUN     = 1'b0;
  localparam logic DISCARD = 1'b1;

  logic          state;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   new_pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] discard_cnt;
  logic [OW-1:0] out_after_rsp;
  logic [CW-1:0] count;
  logic [SW-1:0] used;
  logic          credit_ok;
  logic          gnt;
  logic          push;
  logic          pop;
  fq_entry_t     din;
  fq_entry_t     head;

  // Slots already owned by buffered words plus live requests.
  assign used = SW'(count) + SW'(outstanding)
              - SW'(discard_cnt);
  assign credit_ok = used < SW'(DEPTH);

  assign im_req = !rst && !redirect && credit_ok
               && (outstanding < OW'(MAX_OUTSTANDING));
  assign im_addr = rst ? RESET_PC : fetch_pc;
  assign gnt     = im_req && im_gnt;

  assign new_pc        = redirect_pc & ~32'h3;
  assign out_after_rsp = outstanding - OW'(im_rvalid);

  assign push = im_rvalid && !redirect && (state == RUN);
  assign pop  = instr_valid && instr_ready && !redirect;
  assign din  = '{pc: resp_pc, instr: im_rdata};

  assign instr_valid = !rst && (count != '0);
  assign instr    = instr_valid ? head.instr : FQ_NOP;
  assign instr_pc = instr_valid ? head.pc : FQ_NOP;

  fq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .clear(redirect),
    .din  (din),
    .dout (head),
    .count(count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
      state       <= RUN;
    end else if (redirect) begin
      fetch_pc    <= new_pc;
      resp_pc     <= new_pc;
      outstanding <= out_after_rsp;
      discard_cnt <= out_after_rsp;
      state       <= (out_after_rsp != '0) ? DISCARD : RUN;
    end else begin
      outstanding <= out_after_rsp + OW'(gnt);
      if (gnt) begin
        fetch_pc <= fetch_pc + PC_STEP;
      end
      if (push) begin
        resp_pc <= resp_pc + PC_STEP;
      end
      if (im_rvalid && (state == DISCARD)) begin
        discard_cnt <= discard_cnt - 1'b1;
        if (discard_cnt == OW'(1)) begin
          state <= RUN;
        end
      end
    end
  end

  a_out_max : assert property (
    @(posedge clk) disable iff (rst)
    outstanding <= OW'(MAX_OUTSTANDING));

  a_no_ovf : assert property (
    @(posedge clk) disable iff (rst)
    !(push && (count == CW'(DEPTH)) && !pop));

  a_rsp_ok : assert property (
    @(posedge clk) disable iff (rst)
    im_rvalid |-> (outstanding != '0));

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed vector table, hand sequences
// and randomized traffic against a queue-based reference model.
module tb_ifetch_queue;

  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ifetch_queue #(
    .DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAXO),
    .RESET_PC(RPC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .im_gnt     (im_gnt),
    .im_rvalid  (im_rvalid),
    .im_rdata   (im_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  typedef struct {
    logic        g;
    logic        rv;
    logic [31:0] rd;
    logic        rdir;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
  } vec_t;

  // reference model state
  ent_t        mq[$];
  int          m_out;
  int          m_disc;
  logic [31:0] m_fpc;
  logic [31:0] m_rpc;

  // instruction memory environment
  logic [31:0] p_addr[$];
  int          p_rdy[$];
  int          cyc;
  int          last_rdy;

  vec_t tbl[19];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC3A5_0F00;
  endfunction

  function automatic vec_t mk(
    input logic g, input logic rv, input logic [31:0] rd,
    input logic rdir, input logic [31:0] rpc, input logic rdy,
    input logic e_req, input logic [31:0] e_addr,
    input logic e_val, input logic [31:0] e_pc,
    input logic [31:0] e_ins);
    vec_t v;
    v.g = g; v.rv = rv; v.rd = rd; v.rdir = rdir; v.rpc = rpc;
    v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr;
    v.e_val = e_val; v.e_pc = e_pc; v.e_ins = e_ins;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_out = 0;
    m_disc = 0;
    m_fpc = RPC;
    m_rpc = RPC;
    p_addr.delete();
    p_rdy.delete();
    last_rdy = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    im_gnt = 1'b0;
    im_rvalid = 1'b0;
    im_rdata = '0;
    redirect = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    #1;
    chk("rst.req", 32'(im_req), 0);
    chk("rst.addr", im_addr, RPC);
    chk("rst.valid", 32'(instr_valid), 0);
    chk("rst.pc", instr_pc, 0);
    @(negedge clk);
    #1;
    chk("rst2.req", 32'(im_req), 0);
    chk("rst2.addr", im_addr, RPC);
    chk("rst2.valid", 32'(instr_valid), 0);
    chk("rst2.instr", instr, 0);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic step(input logic g, input logic rdir,
                      input logic [31:0] rpc, input logic rdy,
                      input logic allow, input int lat);
    logic        rv;
    logic [31:0] rd;
    logic        e_req;
    logic        e_val;
    logic        g_ok;
    int          r;
    @(negedge clk);
    rv = allow && (p_addr.size() > 0) && (p_rdy[0] <= cyc);
    rd = rv ? mem_word(p_addr[0]) : $urandom;
    im_gnt = g;
    im_rvalid = rv;
    im_rdata = rd;
    redirect = rdir;
    redirect_pc = rpc;
    instr_ready = rdy;
    #1;
    e_req = !rdir && (m_out < MAXO)
         && (mq.size() + m_out - m_disc < DEPTH);
    e_val = mq.size() > 0;
    chk("m.req", 32'(im_req), 32'(e_req));
    chk("m.addr", im_addr, m_fpc);
    chk("m.valid", 32'(instr_valid), 32'(e_val));
    chk("m.pc", instr_pc, e_val ? mq[0].pc : 32'h0);
    chk("m.instr", instr, e_val ? mq[0].ins : 32'h0);
    if (rv) begin
      void'(p_addr.pop_front());
      void'(p_rdy.pop_front());
    end
    if (im_req && im_gnt) begin
      r = (cyc + lat > last_rdy) ? cyc + lat : last_rdy;
      last_rdy = r;
      p_addr.push_back(im_addr);
      p_rdy.push_back(r);
    end
    g_ok = e_req && g;
    if (rdir) begin
      mq.delete();
      m_out = m_out - int'(rv);
      m_disc = m_out;
      m_fpc = rpc & ~32'h3;
      m_rpc = rpc & ~32'h3;
    end else begin
      if (e_val && rdy) void'(mq.pop_front());
      if (rv) begin
        if (m_disc > 0) begin
          m_disc--;
        end else begin
          mq.push_back('{m_rpc, rd});
          m_rpc = m_rpc + 32'd4;
        end
      end
      m_out = m_out + int'(g_ok) - int'(rv);
      if (g_ok) m_fpc = m_fpc + 32'd4;
    end
    cyc++;
  endtask

  initial begin
    cyc = 0;
    rst = 1'b1;
    model_clear();

    // g rv rdata rdir rpc rdy | req addr valid pc instr
    tbl[0]  = mk(1,0,0,0,0,1, 1,32'h0,0,0,0);
    tbl[1]  = mk(1,1,32'h1000_0000,0,0,1, 1,32'h4,0,0,0);
    tbl[2]  = mk(1,1,32'h1000_0004,0,0,1,
                 1,32'h8,1,32'h0,32'h1000_0000);
    tbl[3]  = mk(1,1,32'h1000_0008,0,0,1,
                 1,32'hC,1,32'h4,32'h1000_0004);
    tbl[4]  = mk(1,0,0,0,0,0, 1,32'h10,1,32'h8,32'h1000_0008);
    tbl[5]  = mk(1,0,0,0,0,0, 0,32'h14,1,32'h8,32'h1000_0008);
    tbl[6]  = mk(1,0,0,1,32'h103,1,
                 0,32'h14,1,32'h8,32'h1000_0008);
    tbl[7]  = mk(0,1,32'h1000_000C,0,0,1, 0,32'h100,0,0,0);
    tbl[8]  = mk(1,1,32'h1000_0010,0,0,1, 1,32'h100,0,0,0);
    tbl[9]  = mk(0,1,32'h1000_0100,0,0,1, 1,32'h104,0,0,0);
    tbl[10] = mk(0,0,0,0,0,0,
                 1,32'h104,1,32'h100,32'h1000_0100);
    tbl[11] = mk(1,0,0,0,0,0,
                 1,32'h104,1,32'h100,32'h1000_0100);
    tbl[12] = mk(1,0,0,0,0,0,
                 1,32'h108,1,32'h100,32'h1000_0100);
    tbl[13] = mk(1,1,32'h1000_0104,1,32'h200,1,
                 0,32'h10C,1,32'h100,32'h1000_0100);
    tbl[14] = mk(1,0,0,1,32'h300,1, 0,32'h200,0,0,0);
    tbl[15] = mk(1,1,32'h1000_0108,0,0,1, 1,32'h300,0,0,0);
    tbl[16] = mk(0,1,32'h1000_0300,0,0,1, 1,32'h304,0,0,0);
    tbl[17] = mk(0,0,0,0,0,1,
                 1,32'h304,1,32'h300,32'h1000_0300);
    tbl[18] = mk(0,0,0,0,0,1, 1,32'h304,0,0,0);

    do_reset();

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      im_gnt = tbl[i].g;
      im_rvalid = tbl[i].rv;
      im_rdata = tbl[i].rd;
      redirect = tbl[i].rdir;
      redirect_pc = tbl[i].rpc;
      instr_ready = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d.req", i), 32'(im_req), 32'(tbl[i].e_req));
      chk($sformatf("v%0d.addr", i), im_addr, tbl[i].e_addr);
      chk($sformatf("v%0d.valid", i), 32'(instr_valid),
          32'(tbl[i].e_val));
      chk($sformatf("v%0d.pc", i), instr_pc, tbl[i].e_pc);
      chk($sformatf("v%0d.instr", i), instr, tbl[i].e_ins);
    end

    // stall fills the queue, then drain
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 1, 1, 1);

    // address wrap at the top of memory
    step(0, 1, 32'hFFFF_FFFD, 1, 1, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 1, 1, 2);

    // reset while the queue is full
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 1, 1);
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 1, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 31) == 0,
           $urandom,
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 7,
           $urandom_range(1, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
